// File: rtl/dma_stream_downsizer_pkg.sv
// Shared types and helpers for the 64-to-32 bit DMA stream downsizer.
package dma_stream_pkg;

  localparam int IN_W   = 64;
  localparam int OUT_W  = 32;
  localparam int STAT_W = 32;

  typedef logic [IN_W-1:0]  beat_t;
  typedef logic [OUT_W-1:0] word_t;

  typedef enum logic {
    HALF_LO = 1'b0,
    HALF_HI = 1'b1
  } half_e;

  function automatic word_t sel_half(input beat_t beat, input half_e half);
    if (half == HALF_HI) begin
      sel_half = beat[IN_W-1:OUT_W];
    end else begin
      sel_half = beat[OUT_W-1:0];
    end
  endfunction

  // Saturating increment so long-running monitors never wrap to zero.
  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] value);
    if (value == {STAT_W{1'b1}}) begin
      sat_inc = value;
    end else begin
      sat_inc = value + {{(STAT_W-1){1'b0}}, 1'b1};
    end
  endfunction

endpackage

// File: rtl/dma_stream_downsizer_if.sv
// Generic valid/ready stream bundle used for both the 64-bit and 32-bit sides.
interface dma_stream_if #(parameter int W = 64);
  logic [W-1:0] data;
  logic         valid;
  logic         ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/dma_stream_downsizer_fifo.sv
// First-word fall-through synchronous FIFO with wrap-bit pointers, flush and fill level.
module sync_fifo_fwft #(
  parameter  int DEPTH = 16,
  parameter  int WIDTH = 64,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             i_flush,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rd_data,
  output logic             o_full,
  output logic             o_empty,
  output logic [AW:0]      o_level
);

  localparam logic [AW:0] PTR_ZERO = {(AW+1){1'b0}};
  localparam logic [AW:0] PTR_ONE  = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_push;
  logic             w_pop;

  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) && (r_wr_ptr[AW] != r_rd_ptr[AW]);
  assign o_level   = r_wr_ptr - r_rd_ptr;
  assign o_rd_data = r_mem[r_rd_ptr[AW-1:0]];
  assign w_push    = i_push & ~o_full & ~i_flush;
  assign w_pop     = i_pop & ~o_empty & ~i_flush;

  // Storage array is deliberately left unreset.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= i_wr_data;
    end
  end

  // Pointer update; flush wins over any push or pop in the same cycle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wr_ptr <= PTR_ZERO;
      r_rd_ptr <= PTR_ZERO;
    end else if (i_flush) begin
      r_wr_ptr <= PTR_ZERO;
      r_rd_ptr <= PTR_ZERO;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
    end
  end

endmodule

// File: rtl/dma_stream_downsizer.sv
// 64-bit to 32-bit stream downsizer (low half first) over a FWFT FIFO.
// Optional statistics counters are enabled by defining DMA_STREAM_STATS_EN.
module dma_stream_downsizer
  import dma_stream_pkg::*;
#(
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        flush,
  dma_stream_if.slave  up,
  dma_stream_if.master dn,
  output logic [AW:0] level
`ifdef DMA_STREAM_STATS_EN
  ,
  output logic [STAT_W-1:0] stall_count,
  output logic [STAT_W-1:0] word_count
`endif
);

  logic  r_rst_done;
  half_e r_half;
  half_e w_half_nxt;
  logic  w_full;
  logic  w_empty;
  logic  w_push;
  logic  w_word_hs;
  logic  w_pop_beat;
  beat_t w_head;

  // in_ready stays low for the first edge after reset release.
  assign up.ready   = ~w_full & ~flush & r_rst_done;
  assign w_push     = up.valid & up.ready;
  assign dn.valid   = ~w_empty;
  assign dn.data    = sel_half(w_head, r_half);
  assign w_word_hs  = dn.valid & dn.ready;
  assign w_pop_beat = w_word_hs & (r_half == HALF_HI);

  sync_fifo_fwft #(
    .DEPTH (DEPTH),
    .WIDTH (IN_W)
  ) u_fifo (
    .clk       (clk),
    .rstn      (rstn),
    .i_flush   (flush),
    .i_push    (w_push),
    .i_wr_data (up.data),
    .i_pop     (w_pop_beat),
    .o_rd_data (w_head),
    .o_full    (w_full),
    .o_empty   (w_empty),
    .o_level   (level)
  );

  // Marks the end of the reset recovery cycle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_rst_done <= 1'b0;
    end else begin
      r_rst_done <= 1'b1;
    end
  end

  // Half-select state register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_half <= HALF_LO;
    end else begin
      r_half <= w_half_nxt;
    end
  end

  // Half-select next state: toggles per accepted word, cleared by flush.
  always_comb begin
    w_half_nxt = r_half;
    if (flush) begin
      w_half_nxt = HALF_LO;
    end else if (w_word_hs) begin
      case (r_half)
        HALF_LO: w_half_nxt = HALF_HI;
        HALF_HI: w_half_nxt = HALF_LO;
        default: w_half_nxt = HALF_LO;
      endcase
    end else begin
      w_half_nxt = r_half;
    end
  end

`ifdef DMA_STREAM_STATS_EN
  logic [STAT_W-1:0] r_stall_count;
  logic [STAT_W-1:0] r_word_count;

  // Flow statistics; only reset clears them.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_stall_count <= {STAT_W{1'b0}};
      r_word_count  <= {STAT_W{1'b0}};
    end else begin
      if (dn.valid & ~dn.ready) begin
        r_stall_count <= sat_inc(r_stall_count);
      end
      if (w_word_hs) begin
        r_word_count <= sat_inc(r_word_count);
      end
    end
  end

  assign stall_count = r_stall_count;
  assign word_count  = r_word_count;
`endif

endmodule

// File: tb/tb_dma_stream_downsizer.sv
// Directed self-checking bench for dma_stream_downsizer (DEPTH=16).
module tb_dma_stream_downsizer;

  logic       clk;
  logic       rstn;
  logic       flush;
  logic [4:0] level;
  int         errors;
  int         checks;
`ifdef DMA_STREAM_STATS_EN
  logic [31:0] stall_count;
  logic [31:0] word_count;
`endif

  dma_stream_if #(.W(64)) up_if ();
  dma_stream_if #(.W(32)) dn_if ();

  dma_stream_downsizer #(.DEPTH(16)) dut (
    .clk   (clk),
    .rstn  (rstn),
    .flush (flush),
    .up    (up_if),
    .dn    (dn_if),
    .level (level)
`ifdef DMA_STREAM_STATS_EN
    ,
    .stall_count (stall_count),
    .word_count  (word_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rstn = 1'b0; flush = 1'b0;
    up_if.valid = 1'b0; up_if.data = 64'h0; dn_if.ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (up_if.ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b want 0", up_if.ready); end
    checks++; if (dn_if.valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", dn_if.valid); end
    checks++; if (level !== 5'd0) begin errors++; $display("FAIL reset_level: got %0d want 0", level); end
    rstn = 1'b1;
    #1;
    checks++; if (up_if.ready !== 1'b0) begin errors++; $display("FAIL reset_ready_before_edge: got %b want 0", up_if.ready); end
    tick();
    checks++; if (up_if.ready !== 1'b1) begin errors++; $display("FAIL reset_ready_after_edge: got %b want 1", up_if.ready); end
  endtask

  task automatic test_single();
    up_if.data = 64'h1111_2222_3333_4444; up_if.valid = 1'b1; dn_if.ready = 1'b1;
    @(negedge clk);
    checks++; if (dn_if.valid !== 1'b0) begin errors++; $display("FAIL single_empty: out_valid %b want 0", dn_if.valid); end
    tick();
    up_if.valid = 1'b0;
    @(negedge clk);
    checks++; if (dn_if.valid !== 1'b1) begin errors++; $display("FAIL single_latency: out_valid %b want 1", dn_if.valid); end
    checks++; if (dn_if.data !== 32'h3333_4444) begin errors++; $display("FAIL single_low: got %h want 33334444", dn_if.data); end
    checks++; if (level !== 5'd1) begin errors++; $display("FAIL single_level1: got %0d want 1", level); end
    tick();
    @(negedge clk);
    checks++; if (dn_if.data !== 32'h1111_2222) begin errors++; $display("FAIL single_high: got %h want 11112222", dn_if.data); end
    tick();
    @(negedge clk);
    checks++; if (dn_if.valid !== 1'b0) begin errors++; $display("FAIL single_drained: out_valid %b want 0", dn_if.valid); end
    checks++; if (level !== 5'd0) begin errors++; $display("FAIL single_level0: got %0d want 0", level); end
    dn_if.ready = 1'b0;
    tick();
  endtask

  task automatic test_full();
    logic [31:0] exp_w;
    dn_if.ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      up_if.data = {32'hB000_0000 + 32'(i), 32'hA000_0000 + 32'(i)}; up_if.valid = 1'b1;
      @(negedge clk);
      checks++; if (up_if.ready !== 1'b1) begin errors++; $display("FAIL full_fill_ready%0d: got %b want 1", i, up_if.ready); end
      tick();
    end
    up_if.data = 64'hDEAD_0017_BEEF_0017;
    @(negedge clk);
    checks++; if (level !== 5'd16) begin errors++; $display("FAIL full_level: got %0d want 16", level); end
    checks++; if (up_if.ready !== 1'b0) begin errors++; $display("FAIL full_ready17: got %b want 0", up_if.ready); end
    tick();
    dn_if.ready = 1'b1;
    @(negedge clk);
    checks++; if (up_if.ready !== 1'b0) begin errors++; $display("FAIL full_ready_lo_pop: got %b want 0", up_if.ready); end
    checks++; if (dn_if.data !== 32'hA000_0000) begin errors++; $display("FAIL full_word0: got %h want a0000000", dn_if.data); end
    tick();
    @(negedge clk);
    checks++; if (up_if.ready !== 1'b0) begin errors++; $display("FAIL full_ready_hi_pop: got %b want 0", up_if.ready); end
    checks++; if (dn_if.data !== 32'hB000_0000) begin errors++; $display("FAIL full_word1: got %h want b0000000", dn_if.data); end
    tick();
    @(negedge clk);
    checks++; if (level !== 5'd15) begin errors++; $display("FAIL full_level15: got %0d want 15", level); end
    checks++; if (up_if.ready !== 1'b1) begin errors++; $display("FAIL full_ready_freed: got %b want 1", up_if.ready); end
    tick();
    up_if.valid = 1'b0; dn_if.ready = 1'b0;
    @(negedge clk);
    checks++; if (level !== 5'd16) begin errors++; $display("FAIL full_17th_accepted: level %0d want 16", level); end
    checks++; if (dn_if.data !== 32'hB000_0001) begin errors++; $display("FAIL full_word3: got %h want b0000001", dn_if.data); end
    tick();
    dn_if.ready = 1'b1;
    tick();
    for (int k = 2; k <= 16; k++) begin
      for (int h = 0; h < 2; h++) begin
        if (k == 16) exp_w = (h == 1) ? 32'hDEAD_0017 : 32'hBEEF_0017;
        else exp_w = (h == 1) ? (32'hB000_0000 + 32'(k)) : (32'hA000_0000 + 32'(k));
        @(negedge clk);
        checks++; if (dn_if.valid !== 1'b1 || dn_if.data !== exp_w) begin errors++; $display("FAIL full_drain: valid %b data %h want %h", dn_if.valid, dn_if.data, exp_w); end
        tick();
      end
    end
    @(negedge clk);
    checks++; if (dn_if.valid !== 1'b0) begin errors++; $display("FAIL full_drained: out_valid %b want 0", dn_if.valid); end
    dn_if.ready = 1'b0;
    tick();
  endtask

  task automatic test_stream();
    int beat;
    int word;
    beat = 0; word = 0;
    dn_if.ready = 1'b1; up_if.valid = 1'b1;
    up_if.data = {32'(2 * beat + 1), 32'(2 * beat)};
    for (int cyc = 0; cyc < 1000; cyc++) begin
      @(negedge clk);
      checks++; if (level > 5'd16) begin errors++; $display("FAIL stream_level_bound: got %0d", level); end
      checks++; if (up_if.ready !== (level != 5'd16)) begin errors++; $display("FAIL stream_ready: got %b level %0d", up_if.ready, level); end
      if (dn_if.valid === 1'b1) begin
        checks++; if (dn_if.data !== 32'(word)) begin errors++; $display("FAIL stream_order: got %h want %h", dn_if.data, 32'(word)); end
        word++;
      end
      if (up_if.ready === 1'b1) beat++;
      tick();
      up_if.data = {32'(2 * beat + 1), 32'(2 * beat)};
    end
    up_if.valid = 1'b0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (dn_if.valid !== 1'b1) break;
      checks++; if (dn_if.data !== 32'(word)) begin errors++; $display("FAIL stream_drain_order: got %h want %h", dn_if.data, 32'(word)); end
      word++;
      tick();
    end
    checks++; if (dn_if.valid !== 1'b0) begin errors++; $display("FAIL stream_drain_bound: out_valid %b want 0", dn_if.valid); end
    checks++; if (word !== 2 * beat) begin errors++; $display("FAIL stream_no_loss: words %0d want %0d", word, 2 * beat); end
    checks++; if (beat < 400) begin errors++; $display("FAIL stream_throughput: beats %0d want >= 400", beat); end
    dn_if.ready = 1'b0;
    tick();
  endtask

  task automatic test_flush();
    dn_if.ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      up_if.data = {32'hF000_0000 + 32'(i), 32'hE000_0000 + 32'(i)}; up_if.valid = 1'b1;
      tick();
    end
    up_if.valid = 1'b0; dn_if.ready = 1'b1;
    tick();
    dn_if.ready = 1'b0;
    @(negedge clk);
    checks++; if (level !== 5'd5) begin errors++; $display("FAIL flush_pre_level: got %0d want 5", level); end
    checks++; if (dn_if.data !== 32'hF000_0000) begin errors++; $display("FAIL flush_pre_half: got %h want f0000000", dn_if.data); end
    tick();
    flush = 1'b1; up_if.valid = 1'b1; up_if.data = 64'h5555_5555_5555_5555; dn_if.ready = 1'b1;
    @(negedge clk);
    checks++; if (up_if.ready !== 1'b0) begin errors++; $display("FAIL flush_ready: got %b want 0", up_if.ready); end
    tick();
    flush = 1'b0; up_if.valid = 1'b0; dn_if.ready = 1'b0;
    @(negedge clk);
    checks++; if (level !== 5'd0) begin errors++; $display("FAIL flush_level: got %0d want 0", level); end
    checks++; if (dn_if.valid !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b want 0", dn_if.valid); end
    tick();
    up_if.data = 64'h0000_000A_0000_000B; up_if.valid = 1'b1; dn_if.ready = 1'b1;
    tick();
    up_if.valid = 1'b0;
    @(negedge clk);
    checks++; if (dn_if.data !== 32'h0000_000B) begin errors++; $display("FAIL flush_after_low: got %h want 0000000b", dn_if.data); end
    tick();
    @(negedge clk);
    checks++; if (dn_if.data !== 32'h0000_000A) begin errors++; $display("FAIL flush_after_high: got %h want 0000000a", dn_if.data); end
    tick();
    @(negedge clk);
    checks++; if (dn_if.valid !== 1'b0) begin errors++; $display("FAIL flush_after_empty: got %b want 0", dn_if.valid); end
    dn_if.ready = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    dn_if.ready = 1'b0;
    for (int i = 0; i < 7; i++) begin
      up_if.data = {32'h7100_0000 + 32'(i), 32'h7000_0000 + 32'(i)}; up_if.valid = 1'b1;
      tick();
    end
    up_if.valid = 1'b0;
    @(negedge clk);
    checks++; if (level !== 5'd7) begin errors++; $display("FAIL rstmid_pre_level: got %0d want 7", level); end
    tick();
    up_if.data = 64'hCAFE_0001_BEEF_0002; up_if.valid = 1'b1;
    #2 rstn = 1'b0;
    #1;
    checks++; if (level !== 5'd0) begin errors++; $display("FAIL rstmid_level: got %0d want 0", level); end
    checks++; if (dn_if.valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid: got %b want 0", dn_if.valid); end
    checks++; if (up_if.ready !== 1'b0) begin errors++; $display("FAIL rstmid_ready: got %b want 0", up_if.ready); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (level !== 5'd0) begin errors++; $display("FAIL rstmid_no_accept: level %0d want 0", level); end
    rstn = 1'b1;
    tick();
    @(negedge clk);
    checks++; if (up_if.ready !== 1'b1 || level !== 5'd0) begin errors++; $display("FAIL rstmid_release: ready %b level %0d want 1/0", up_if.ready, level); end
    tick();
    up_if.valid = 1'b0; dn_if.ready = 1'b1;
    @(negedge clk);
    checks++; if (dn_if.data !== 32'hBEEF_0002 || level !== 5'd1) begin errors++; $display("FAIL rstmid_first_low: data %h level %0d want beef0002/1", dn_if.data, level); end
    tick();
    @(negedge clk);
    checks++; if (dn_if.data !== 32'hCAFE_0001) begin errors++; $display("FAIL rstmid_first_high: got %h want cafe0001", dn_if.data); end
    tick();
    @(negedge clk);
    checks++; if (dn_if.valid !== 1'b0) begin errors++; $display("FAIL rstmid_empty: got %b want 0", dn_if.valid); end
    dn_if.ready = 1'b0;
    tick();
  endtask

`ifdef DMA_STREAM_STATS_EN
  task automatic test_stats();
    rstn = 1'b0;
    @(negedge clk);
    checks++; if (stall_count !== 32'd0 || word_count !== 32'd0) begin errors++; $display("FAIL stats_reset: stall %0d words %0d want 0/0", stall_count, word_count); end
    rstn = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      up_if.data = {32'h9100_0000 + 32'(i), 32'h9000_0000 + 32'(i)}; up_if.valid = 1'b1;
      tick();
    end
    up_if.valid = 1'b0;
    repeat (7) tick();
    @(negedge clk);
    checks++; if (stall_count !== 32'd10 || word_count !== 32'd0) begin errors++; $display("FAIL stats_stall: stall %0d words %0d want 10/0", stall_count, word_count); end
    dn_if.ready = 1'b1;
    repeat (8) tick();
    dn_if.ready = 1'b0;
    @(negedge clk);
    checks++; if (stall_count !== 32'd10 || word_count !== 32'd8) begin errors++; $display("FAIL stats_words: stall %0d words %0d want 10/8", stall_count, word_count); end
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    @(negedge clk);
    checks++; if (stall_count !== 32'd10 || word_count !== 32'd8) begin errors++; $display("FAIL stats_flush: stall %0d words %0d want 10/8", stall_count, word_count); end
    tick();
  endtask
`endif

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_single();
    test_full();
    test_stream();
    test_flush();
    test_reset_mid();
`ifdef DMA_STREAM_STATS_EN
    test_stats();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
